// File: rtl/sb_rx_pkg.sv
// rtl/sb_rx_pkg.sv - opcodes, header fields, FSM encoding and helpers for the sideband RX dispatcher
package sb_rx_pkg;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 4;
    localparam int CP_BIT  = 62;
    localparam int DP_BIT  = 63;

    localparam logic [4:0] OPC_MSG_NODATA  = 5'b10010;
    localparam logic [4:0] OPC_MSG_DATA64  = 5'b11011;
    localparam logic [4:0] OPC_CFG_WR64    = 5'b00101;
    localparam logic [4:0] OPC_CMPL_DATA64 = 5'b10001;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HDR_WAIT  = 3'd1;
    localparam logic [2:0] ST_HDR_CHK   = 3'd2;
    localparam logic [2:0] ST_DATA_REQ  = 3'd3;
    localparam logic [2:0] ST_DATA_WAIT = 3'd4;
    localparam logic [2:0] ST_SEND      = 3'd5;

    // Opcodes whose header is followed by one 64-bit data flit.
    function automatic logic f_has_data(input logic [4:0] opcode);
        return (opcode == OPC_MSG_DATA64) || (opcode == OPC_CFG_WR64) ||
               (opcode == OPC_CMPL_DATA64);
    endfunction

    // Opcodes consumed by the link training state machine; all others go to RDI.
    function automatic logic f_route_ltsm(input logic [4:0] opcode);
        return (opcode == OPC_MSG_NODATA) || (opcode == OPC_MSG_DATA64);
    endfunction

    // CP covers bits 61:0, so CP equals their XOR exactly when the XOR of
    // every bit except DP is zero.
    function automatic logic f_hdr_parity_ok(input logic [63:0] hdr);
        logic [63:0] dp_mask;
        dp_mask = ~(64'd1 << DP_BIT);
        return ~(^(hdr & dp_mask));
    endfunction

endpackage

// File: rtl/sb_rx_msg_dispatcher.sv
// rtl/sb_rx_msg_dispatcher.sv - drains the sideband RX FIFO, checks header parity and routes packets to LTSM or RDI
module sb_rx_msg_dispatcher
    import sb_rx_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_fifo_empty,
    input  logic [63:0]       i_fifo_data,
    output logic              o_fifo_read_enable,
    output logic              o_ltsm_valid,
    output logic [63:0]       o_ltsm_hdr,
    output logic [63:0]       o_ltsm_data,
    output logic              o_ltsm_has_data,
    input  logic              i_ltsm_ready,
    output logic              o_rdi_valid,
    output logic [63:0]       o_rdi_hdr,
    output logic [63:0]       o_rdi_data,
    output logic              o_rdi_has_data,
    input  logic              i_rdi_ready,
    output logic              o_parity_err,
    output logic              o_timeout_err,
    output logic [CNT_W-1:0]  o_drop_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]       state;
    logic [63:0]      hdr_q;
    logic [63:0]      data_q;
    logic             has_data_q;
    logic             ltsm_valid_q;
    logic             rdi_valid_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [4:0]       opcode;
    logic             route_ltsm;
    logic             xfer_done;

    assign opcode     = hdr_q[OPC_MSB:OPC_LSB];
    assign route_ltsm = f_route_ltsm(opcode);
    assign xfer_done  = (ltsm_valid_q && i_ltsm_ready) || (rdi_valid_q && i_rdi_ready);

    // Both consumers see the same packet registers; only the valids differ.
    assign o_ltsm_valid    = ltsm_valid_q;
    assign o_ltsm_hdr      = hdr_q;
    assign o_ltsm_data     = data_q;
    assign o_ltsm_has_data = has_data_q;
    assign o_rdi_valid     = rdi_valid_q;
    assign o_rdi_hdr       = hdr_q;
    assign o_rdi_data      = data_q;
    assign o_rdi_has_data  = has_data_q;

    // Pop is decoded from the current state so the FIFO's registered read data
    // lands in the very next (wait) state. The states following a pop never
    // look at the empty flag, which hides its one-cycle lag.
    always_comb begin
        o_fifo_read_enable = 1'b0;
        if (!i_rst) begin
            if (state == ST_IDLE) begin
                o_fifo_read_enable = i_enable && !i_fifo_empty;
            end else if (state == ST_DATA_REQ) begin
                o_fifo_read_enable = !i_fifo_empty;
            end
        end
    end

    // Packet assembly FSM, timeout counter, error pulses and drop counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            hdr_q         <= '0;
            data_q        <= '0;
            has_data_q    <= 1'b0;
            ltsm_valid_q  <= 1'b0;
            rdi_valid_q   <= 1'b0;
            tmo_cnt       <= '0;
            o_parity_err  <= 1'b0;
            o_timeout_err <= 1'b0;
            o_drop_count  <= '0;
        end else begin
            o_parity_err  <= 1'b0;
            o_timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (o_fifo_read_enable) begin
                        state <= ST_HDR_WAIT;
                    end
                end
                ST_HDR_WAIT: begin
                    hdr_q <= i_fifo_data;
                    state <= ST_HDR_CHK;
                end
                ST_HDR_CHK: begin
                    if (!f_hdr_parity_ok(hdr_q)) begin
                        o_parity_err <= 1'b1;
                        if (o_drop_count != '1) begin
                            o_drop_count <= o_drop_count + CNT_W'(1);
                        end
                        state <= ST_IDLE;
                    end else if (f_has_data(opcode)) begin
                        tmo_cnt <= '0;
                        state   <= ST_DATA_REQ;
                    end else begin
                        data_q       <= '0;
                        has_data_q   <= 1'b0;
                        ltsm_valid_q <= route_ltsm;
                        rdi_valid_q  <= !route_ltsm;
                        state        <= ST_SEND;
                    end
                end
                ST_DATA_REQ: begin
                    if (!i_fifo_empty) begin
                        state <= ST_DATA_WAIT;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        o_timeout_err <= 1'b1;
                        if (o_drop_count != '1) begin
                            o_drop_count <= o_drop_count + CNT_W'(1);
                        end
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DATA_WAIT: begin
                    data_q       <= i_fifo_data;
                    has_data_q   <= 1'b1;
                    ltsm_valid_q <= route_ltsm;
                    rdi_valid_q  <= !route_ltsm;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer_done) begin
                        ltsm_valid_q <= 1'b0;
                        rdi_valid_q  <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_rx_msg_dispatcher.sv
// tb/tb_sb_rx_msg_dispatcher.sv - randomized self-checking bench for sb_rx_msg_dispatcher
module tb_sb_rx_msg_dispatcher;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [63:0] fifo_data = '0;
    logic        rd;
    logic        ltsm_valid, ltsm_has_data, rdi_valid, rdi_has_data;
    logic [63:0] ltsm_hdr, ltsm_data, rdi_hdr, rdi_data;
    logic        ltsm_ready = 1'b0;
    logic        rdi_ready = 1'b0;
    logic        parity_err, timeout_err;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    sb_rx_msg_dispatcher #(.CNT_W(8), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_read_enable(rd),
        .o_ltsm_valid(ltsm_valid), .o_ltsm_hdr(ltsm_hdr), .o_ltsm_data(ltsm_data),
        .o_ltsm_has_data(ltsm_has_data), .i_ltsm_ready(ltsm_ready),
        .o_rdi_valid(rdi_valid), .o_rdi_hdr(rdi_hdr), .o_rdi_data(rdi_data),
        .o_rdi_has_data(rdi_has_data), .i_rdi_ready(rdi_ready),
        .o_parity_err(parity_err), .o_timeout_err(timeout_err), .o_drop_count(drop_count)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec rules for the model
    function automatic logic good_par(input logic [63:0] h);
        return (^h[61:0]) == h[62];
    endfunction
    function automatic logic carries(input logic [4:0] o);
        return o == 5'b11011 || o == 5'b00101 || o == 5'b10001;
    endfunction
    function automatic logic to_ltsm(input logic [4:0] o);
        return o == 5'b10010 || o == 5'b11011;
    endfunction
    function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input logic [63:0] r, input logic bad);
        logic [63:0] h;
        h = r;
        h[4:0] = opc;
        h[62] = (^h[61:0]) ^ bad;
        return h;
    endfunction

    // FIFO model: registered data, registered empty flag lagging a pop by one cycle
    logic [63:0] fq[$];
    logic        wr_en = 1'b0;
    logic [63:0] wr_data = '0;
    int          pops = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fifo_empty <= (fq.size() == 0);
        if (rd) begin
            chk("pop_nonempty", 64'(fq.size() != 0), 64'd1);
            if (fq.size() != 0) fifo_data <= fq.pop_front();
            pops++;
        end
        if (wr_en) fq.push_back(wr_data);
    end

    // Expected event stream: kind 0 LTSM, 1 RDI, 2 parity drop, 3 timeout drop
    typedef struct {
        int          kind;
        logic [63:0] hdr;
        logic [63:0] data;
        logic        hd;
    } ev_t;
    ev_t         exp_q[$];
    logic        pend = 1'b0;
    logic [63:0] pend_hdr = '0;
    int          model_drops = 0;

    task automatic model_flit(input logic [63:0] f);
        ev_t e;
        e.hdr = f; e.data = '0; e.hd = 1'b0; e.kind = 0;
        if (pend) begin
            e.kind = to_ltsm(pend_hdr[4:0]) ? 0 : 1;
            e.hdr = pend_hdr; e.data = f; e.hd = 1'b1;
            pend = 1'b0;
            exp_q.push_back(e);
        end else if (!good_par(f)) begin
            e.kind = 2;
            exp_q.push_back(e);
        end else if (carries(f[4:0])) begin
            pend = 1'b1;
            pend_hdr = f;
        end else begin
            e.kind = to_ltsm(f[4:0]) ? 0 : 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_timeout();
        ev_t e;
        e.kind = 3; e.hdr = pend_hdr; e.data = '0; e.hd = 1'b0;
        pend = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [63:0] h, input logic [63:0] d, input logic hd);
        ev_t e;
        chk("event_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (kind < 2) begin
                chk("pkt_hdr", h, e.hdr);
                chk("pkt_data", d, e.data);
                chk("pkt_has_data", 64'(hd), 64'(e.hd));
            end
            if (kind >= 2) model_drops++;
        end
    endtask

    // Per-cycle compare process
    logic        chk_on = 1'b0;
    logic        pl_v = 1'b0, pr_v = 1'b0;
    logic [63:0] pl_h, pl_d, pr_h, pr_d;
    logic        pl_hd, pr_hd;

    always @(negedge clk) begin
        if (rst || !chk_on) begin
            pl_v <= 1'b0;
            pr_v <= 1'b0;
        end else begin
            chk("both_valid", 64'(ltsm_valid & rdi_valid), 64'd0);
            if (pl_v) begin
                chk("ltsm_hold_valid", 64'(ltsm_valid), 64'd1);
                chk("ltsm_hold_hdr", ltsm_hdr, pl_h);
                chk("ltsm_hold_data", ltsm_data, pl_d);
                chk("ltsm_hold_hd", 64'(ltsm_has_data), 64'(pl_hd));
            end
            if (pr_v) begin
                chk("rdi_hold_valid", 64'(rdi_valid), 64'd1);
                chk("rdi_hold_hdr", rdi_hdr, pr_h);
                chk("rdi_hold_data", rdi_data, pr_d);
                chk("rdi_hold_hd", 64'(rdi_has_data), 64'(pr_hd));
            end
            if (ltsm_valid && ltsm_ready) check_ev(0, ltsm_hdr, ltsm_data, ltsm_has_data);
            if (rdi_valid && rdi_ready) check_ev(1, rdi_hdr, rdi_data, rdi_has_data);
            if (parity_err) check_ev(2, '0, '0, 1'b0);
            if (timeout_err) check_ev(3, '0, '0, 1'b0);
            chk("drop_count", 64'(drop_count), 64'((model_drops > 255) ? 255 : model_drops));
            pl_v <= ltsm_valid && !ltsm_ready;
            pr_v <= rdi_valid && !rdi_ready;
            pl_h <= ltsm_hdr; pl_d <= ltsm_data; pl_hd <= ltsm_has_data;
            pr_h <= rdi_hdr;  pr_d <= rdi_data;  pr_hd <= rdi_has_data;
        end
    end

    // Random handshake / enable driver
    logic rand_mode = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) begin
            ltsm_ready = ($urandom_range(0, 1) == 1);
            rdi_ready  = ($urandom_range(0, 1) == 1);
            enable     = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0: return rd;
            1: return ltsm_valid;
            2: return rdi_valid;
            3: return parity_err;
            4: return timeout_err;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic any_out();
        return |{rd, ltsm_valid, ltsm_hdr, ltsm_data, ltsm_has_data, rdi_valid, rdi_hdr,
                 rdi_data, rdi_has_data, parity_err, timeout_err, drop_count};
    endfunction

    task automatic wait_for(input int s, input int limit, input string name);
        int n = 0;
        while (!sig(s) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(sig(s)), 64'd1);
    endtask

    task automatic push_flit(input logic [63:0] f);
        int n = 0;
        while (fq.size() >= 4 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        model_flit(f);
        wr_en = 1'b1;
        wr_data = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pend || fq.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    longint      t0;
    int          p0;
    int          hold;
    logic [63:0] h;
    logic [4:0]  opc_tab [6];

    initial begin
        opc_tab[0] = 5'b10010; opc_tab[1] = 5'b11011; opc_tab[2] = 5'b00101;
        opc_tab[3] = 5'b10001; opc_tab[4] = 5'b00000; opc_tab[5] = 5'b01110;

        chk("pin_parity_good", 64'(good_par(64'h4000_0000_0000_0112)), 64'd1);
        chk("pin_parity_bad", 64'(good_par(64'h4000_0000_0000_0012)), 64'd0);
        chk("pin_classes", {61'd0, carries(5'b00101), to_ltsm(5'b11011), to_ltsm(5'b10001)}, 64'b110);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(any_out()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; enable = 1'b1; ltsm_ready = 1'b1; rdi_ready = 1'b1; chk_on = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 64'(any_out()), 64'd0);

        // 1: LTSM no-data packet, latency from pop to valid
        p0 = pops;
        push_flit(64'h4000_0000_0000_0112);
        wait_for(0, 50, "t1_pop");
        t0 = cyc;
        wait_for(1, 50, "t1_valid");
        chk("t1_latency", 64'(cyc - t0), 64'd3);
        chk("t1_has_data", 64'(ltsm_has_data), 64'd0);
        chk("t1_data", ltsm_data, 64'd0);
        wait_drain("t1_drain");
        chk("t1_pops", 64'(pops - p0), 64'd1);

        // 2: data packet to RDI under 10 cycles of backpressure
        @(posedge clk);
        #1;
        rdi_ready = 1'b0;
        p0 = pops;
        push_flit(mk_hdr(5'b00101, {$urandom, $urandom}, 1'b0));
        push_flit(64'hDEAD_BEEF_0123_4567);
        wait_for(2, 50, "t2_valid");
        hold = 1;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (rdi_valid) hold++;
        end
        chk("t2_hold_cycles", 64'(hold), 64'd10);
        @(posedge clk);
        #1;
        rdi_ready = 1'b1;
        @(negedge clk);
        chk("t2_xfer_valid", 64'(rdi_valid), 64'd1);
        chk("t2_data", rdi_data, 64'hDEAD_BEEF_0123_4567);
        chk("t2_has_data", 64'(rdi_has_data), 64'd1);
        @(negedge clk);
        chk("t2_valid_drop", 64'(rdi_valid), 64'd0);
        wait_drain("t2_drain");
        chk("t2_pops", 64'(pops - p0), 64'd2);

        // 3: parity error then a good packet
        chk("t3_drop_before", 64'(drop_count), 64'd0);
        push_flit(mk_hdr(5'b10010, {$urandom, $urandom}, 1'b1));
        wait_for(3, 50, "t3_perr");
        chk("t3_drop_after", 64'(drop_count), 64'd1);
        @(negedge clk);
        chk("t3_perr_single", 64'(parity_err), 64'd0);
        push_flit(mk_hdr(5'b10010, {$urandom, $urandom}, 1'b0));
        wait_drain("t3_drain");

        // 4: data flit never arrives
        push_flit(mk_hdr(5'b11011, {$urandom, $urandom}, 1'b0));
        model_timeout();
        wait_for(0, 50, "t4_pop");
        t0 = cyc;
        wait_for(4, 400, "t4_tmo");
        chk("t4_latency", 64'(cyc - t0), 64'(3 + TMO));
        chk("t4_drop", 64'(drop_count), 64'd2);
        push_flit(mk_hdr(5'b00000, {$urandom, $urandom}, 1'b0));
        wait_drain("t4_drain");

        // 5: reset while in DATA_WAIT
        push_flit(mk_hdr(5'b10001, {$urandom, $urandom}, 1'b0));
        push_flit({$urandom, $urandom});
        wait_for(0, 50, "t5_pop_hdr");
        @(posedge clk);
        #1;
        wait_for(0, 50, "t5_pop_data");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pend = 1'b0;
        model_drops = 0;
        @(negedge clk);
        chk("t5_outputs_zero", 64'(any_out()), 64'd0);
        chk("t5_drop_zero", 64'(drop_count), 64'd0);
        repeat (5) @(negedge clk);

        // 6: four mixed packets, both readies high
        push_flit(mk_hdr(5'b10010, {$urandom, $urandom}, 1'b0));
        push_flit(mk_hdr(5'b00101, {$urandom, $urandom}, 1'b0));
        push_flit({$urandom, $urandom});
        push_flit(mk_hdr(5'b11011, {$urandom, $urandom}, 1'b0));
        push_flit({$urandom, $urandom});
        push_flit(mk_hdr(5'b00011, {$urandom, $urandom}, 1'b0));
        wait_drain("t6_drain");

        // random traffic with random readies and enable
        rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic bad;
            logic [4:0] o;
            o = opc_tab[$urandom_range(0, 5)];
            if (o == 5'b01110) o = 5'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            h = mk_hdr(o, {$urandom, $urandom}, bad);
            push_flit(h);
            if (!bad && carries(o)) push_flit({$urandom, $urandom});
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain("rand_drain");
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        ltsm_ready = 1'b1; rdi_ready = 1'b1; enable = 1'b1;

        // drop counter saturation
        for (int i = 0; i < 300; i++) begin
            push_flit(mk_hdr(5'($urandom), {$urandom, $urandom}, 1'b1));
        end
        wait_drain("sat_drain");
        chk("sat_drop", 64'(drop_count), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

endmodule
